// File: rtl/vending_machine_if.sv
// Keypad and display pin bundle of the vending controller.
// slave is the controller side; master is the keypad/display side.
interface vending_machine_if;
  logic [3:0] row;
  logic [3:0] shift_col;
  logic [6:0] D0;
  logic [6:0] D1;
  logic [6:0] D2;

  modport master (output row, input shift_col, D0, D1, D2);
  modport slave  (input row, output shift_col, D0, D1, D2);
endinterface

// File: rtl/vending_machine.sv
// Coin-credit vending controller: 4x4 keypad column scan with debounce, credit register,
// and a three-digit active-low seven-segment display (key sample to display: 2 cycles).
module vending_machine #(
  parameter int SCAN_DIV   = 4,
  parameter int MAX_CREDIT = 995
) (
  input  logic              clk,
  input  logic              reset,
  vending_machine_if.slave  kp
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_t;

  col_t          col, col_nxt;
  logic [CW-1:0] scan_cnt, scan_cnt_nxt;
  logic          last_dwell;

  logic [3:0] row_meta, row_sync;
  logic       key_det;
  logic [1:0] key_row;

  logic       key_held;
  logic [1:0] idle_cnt;
  logic       evt;
  logic [1:0] evt_col, evt_row;

  logic [9:0]  credit;
  logic [9:0]  amt;
  logic [10:0] sum;
  logic        is_coin, is_buy, is_cancel;
  logic [21:0] dd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col      <= COL0;
      scan_cnt <= '0;
    end else begin
      col      <= col_nxt;
      scan_cnt <= scan_cnt_nxt;
    end
  end

  always_comb begin
    col_nxt      = col;
    scan_cnt_nxt = scan_cnt + 1'b1;
    last_dwell   = (scan_cnt == CW'(SCAN_DIV - 1));
    kp.shift_col = 4'b1110;
    case (col)
      COL0: kp.shift_col = 4'b1110;
      COL1: kp.shift_col = 4'b1101;
      COL2: kp.shift_col = 4'b1011;
      COL3: kp.shift_col = 4'b0111;
      default: kp.shift_col = 4'b1110;
    endcase
    if (last_dwell) begin
      scan_cnt_nxt = '0;
      case (col)
        COL0: col_nxt = COL1;
        COL1: col_nxt = COL2;
        COL2: col_nxt = COL3;
        COL3: col_nxt = COL0;
        default: col_nxt = COL0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= kp.row;
      row_sync <= row_meta;
    end
  end

  // Lowest pressed row index wins when several rows are low.
  always_comb begin
    key_det = ~&row_sync;
    if (!row_sync[0])      key_row = 2'd0;
    else if (!row_sync[1]) key_row = 2'd1;
    else if (!row_sync[2]) key_row = 2'd2;
    else                   key_row = 2'd3;
  end

  // key_held drops only after four consecutive empty column samples (one full scan).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_held <= 1'b0;
      idle_cnt <= '0;
      evt      <= 1'b0;
      evt_col  <= '0;
      evt_row  <= '0;
    end else begin
      evt <= 1'b0;
      if (last_dwell) begin
        if (key_det) begin
          idle_cnt <= '0;
          if (!key_held) begin
            key_held <= 1'b1;
            evt      <= 1'b1;
            evt_col  <= col;
            evt_row  <= key_row;
          end
        end else if (key_held) begin
          if (idle_cnt == 2'd3) begin
            key_held <= 1'b0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    is_coin   = (evt_col == 2'd0);
    is_buy    = (evt_col == 2'd1);
    is_cancel = (evt_col == 2'd2) && (evt_row == 2'd0);
    amt       = '0;
    case ({evt_col, evt_row})
      4'b00_00: amt = 10'd5;
      4'b00_01: amt = 10'd10;
      4'b00_10: amt = 10'd25;
      4'b00_11: amt = 10'd100;
      4'b01_00: amt = 10'd50;
      4'b01_01: amt = 10'd75;
      4'b01_10: amt = 10'd100;
      4'b01_11: amt = 10'd125;
      default:  amt = 10'd0;
    endcase
    sum = {1'b0, credit} + {1'b0, amt};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit <= '0;
    end else if (evt) begin
      if (is_coin && (sum <= 11'(MAX_CREDIT)))
        credit <= sum[9:0];
      else if (is_buy && (credit >= amt))
        credit <= credit - amt;
      else if (is_cancel)
        credit <= '0;
    end
  end

  // Double-dabble: BCD digits end up in dd[21:10].
  always_comb begin
    dd = {12'd0, credit};
    for (int i = 0; i < 10; i++) begin
      if (dd[13:10] >= 4'd5) dd[13:10] = dd[13:10] + 4'd3;
      if (dd[17:14] >= 4'd5) dd[17:14] = dd[17:14] + 4'd3;
      if (dd[21:18] >= 4'd5) dd[21:18] = dd[21:18] + 4'd3;
      dd = dd << 1;
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kp.D0 <= 7'b1000000;
      kp.D1 <= 7'b1000000;
      kp.D2 <= 7'b1000000;
    end else begin
      kp.D0 <= seg(dd[13:10]);
      kp.D1 <= seg(dd[17:14]);
      kp.D2 <= seg(dd[21:18]);
    end
  end
endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: a keypad model drives rows from the scanned column,
// and each step checks scan order or the displayed credit against hand-computed values.
module tb_vending_machine;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vending_machine_if bus();

  vending_machine #(.SCAN_DIV(4), .MAX_CREDIT(995)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic       key_on = 1'b0;
  int         key_c = 0;
  logic [3:0] key_mask = 4'b0000;

  // Pressed rows pull low only while their column is being driven.
  assign bus.row = (key_on && (bus.shift_col[key_c] == 1'b0)) ? ~key_mask : 4'b1111;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input int v);
    chk({tag, "_D2"}, bus.D2, seg_tab[(v / 100) % 10]);
    chk({tag, "_D1"}, bus.D1, seg_tab[(v / 10) % 10]);
    chk({tag, "_D0"}, bus.D0, seg_tab[v % 10]);
  endtask

  task automatic press(input int c, input logic [3:0] mask);
    key_c    = c;
    key_mask = mask;
    key_on   = 1'b1;
    repeat (40) @(negedge clk);
    key_on   = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_col;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_col", {3'b000, bus.shift_col}, 7'b0001110);
    chk_disp("rst", 0);
    reset = 1'b0;

    for (int k = 0; k < 20; k++) begin
      exp_col = 4'b1111;
      exp_col[(k / 4) % 4] = 1'b0;
      chk($sformatf("scan%0d", k), {3'b000, bus.shift_col}, {3'b000, exp_col});
      @(negedge clk);
    end

    press(0, 4'b0001);              // +5, held over two scans
    chk_disp("coin5", 5);
    press(2, 4'b0001);              // cancel
    chk_disp("cancel1", 0);
    press(0, 4'b0100);
    press(0, 4'b0100);
    press(0, 4'b1000);
    chk_disp("c150", 150);
    press(1, 4'b0010);              // buy B
    chk_disp("buyB", 75);
    press(1, 4'b1000);              // buy D, too expensive
    chk_disp("buyD_rej", 75);
    press(3, 4'b0001);              // unmapped key
    chk_disp("ignored", 75);
    press(0, 4'b1010);              // rows 1 and 3: row 1 (+10) wins
    chk_disp("multirow", 85);

    for (int i = 0; i < 9; i++) press(0, 4'b1000);
    chk_disp("c985", 985);
    press(0, 4'b0010);
    chk_disp("c995", 995);
    press(0, 4'b0010);              // 1005 rejected
    chk_disp("over10", 995);
    press(0, 4'b0001);              // 1000 rejected
    chk_disp("over5", 995);
    press(2, 4'b0001);
    chk_disp("cancel2", 0);

    press(0, 4'b0100);
    press(0, 4'b0100);
    press(1, 4'b0001);              // buy A at exactly its price
    chk_disp("buyA_exact", 0);

    press(0, 4'b0001);
    press(0, 4'b0010);
    key_c    = 0;
    key_mask = 4'b0100;
    key_on   = 1'b1;                // hold +25
    repeat (40) @(negedge clk);
    chk_disp("held40", 40);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_col", {3'b000, bus.shift_col}, 7'b0001110);
    chk_disp("arst", 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk_disp("post_rst_evt", 25);
    key_on = 1'b0;
    repeat (40) @(negedge clk);
    chk_disp("post_rst_rel", 25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
